alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Front-end controller for the 32-bit ALU top level: the unit with the dataA/dataB/signal/dataOut interface, the multi-cycle divider and the HI/LO registers.
- Accepts one operation at a time from a requester over a valid/ready handshake.
- Drives the ALU operands and 6-bit function code, and holds them for the required number of cycles. For divides, waits out the divider latency.
- Returns the result over a valid/ready response channel, so callers never track ALU or divider timing themselves.

Parameters:
- ALU_LAT, 2: cycles from applying signal until dataOut is valid for single-cycle ops (1 for the registered function-code decode, 1 settle).
- DIV_CYCLES, 32: cycles DIVU must be held on signal before HI/LO are valid.
- NOP_FUNCT, 6'h00: function code driven when idle (SLL with B=0; harmless).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_funct  in  6  MIPS funct code.
- req_a  in  32  operand A.
- req_b  in  32  operand B, or shift amount.
- alu_dataA  out  32  to ALU dataA.
- alu_dataB  out  32  to ALU dataB.
- alu_signal  out  6  to ALU signal.
- alu_reset  out  1  to ALU reset.
- alu_dataOut  in  32  from ALU dataOut.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  result.
- rsp_err  out  1  unsupported funct.
- busy  out  1  state != IDLE.

Behaviour:
- Supported funct codes:
  - Single-cycle class: ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLL 0x00, SRL 0x02.
  - Divide class: DIVU 0x1B.
  - HI/LO read class: MFHI 0x10, MFLO 0x12.
  - Any other code is an error.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0; alu_signal=NOP_FUNCT; alu_dataA=alu_dataB=0.
- alu_reset = reset, passed straight through so the ALU-internal HI/LO and divider clear together with the sequencer.
- States and transitions:
  - IDLE: req_ready=1.
    - On req_valid & req_ready: register funct/a/b into alu_* outputs and load counter.
    - Single-cycle or HI/LO read: counter=ALU_LAT-1, go to EXEC.
    - DIVU: counter=DIV_CYCLES-1, go to DIV_WAIT.
    - Unsupported: go to RESP with rsp_err=1, rsp_data=0; the ALU is not driven (alu_signal stays NOP_FUNCT).
  - EXEC: hold alu_* stable; decrement counter. At counter==0, capture alu_dataOut into rsp_data, go to RESP.
  - DIV_WAIT: hold DIVU, dataA, dataB stable; decrement counter. At counter==0, drive alu_signal=NOP_FUNCT and go to RESP with rsp_data=0 (acknowledge only; quotient/remainder are read later via MFLO/MFHI).
  - RESP: rsp_valid=1; rsp_data/rsp_err stable until handshake. On rsp_ready, go to IDLE and clear rsp_valid and rsp_err. alu_signal=NOP_FUNCT throughout RESP.
- req_ready is 1 only in IDLE; there is no request/response overlap, and back-to-back throughput is one op per (latency + 2) cycles minimum.
- Latency from accept to rsp_valid:
  - single-cycle and MFHI/MFLO: ALU_LAT+1 cycles;
  - DIVU: DIV_CYCLES+1 cycles;
  - unsupported: 1 cycle.
- Divide by zero is not trapped; the result is whatever the divider produces, and the sequencer completes normally.
- rsp_ready held high in advance: the response completes in its first RESP cycle.
- req_valid deasserted while not ready: ignored, no state change.
- reset mid-operation (any state): next edge returns to IDLE with all reset values. Any pending response is discarded; HI/LO are cleared through alu_reset.
- Counter width: clog2(max(ALU_LAT, DIV_CYCLES)) bits; no wrap, because it is loaded only from IDLE.

Test Plan:
- ADD: a=5, b=7, funct 0x20, rsp_ready=1 -> rsp_valid 3 cycles after accept; rsp_data=12, rsp_err=0; busy high throughout.
- DIVU then reads: DIVU a=100, b=7 -> ack after 33 cycles, rsp_data=0. Then MFLO -> 14, then MFHI -> 2. alu_signal equals 0x1B for exactly 32 cycles.
- Backpressure: SUB a=3, b=5 with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data=32'hFFFFFFFE held stable; req_ready=0 until the handshake, then 1 on the next cycle.
- Unsupported funct 0x3F -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0; alu_signal never leaves NOP_FUNCT.
- Reset during DIV_WAIT (cycle 10 of 32) -> next cycle IDLE, req_ready=1, rsp_valid=0. A following MFLO returns 0.
- Back-to-back SRL a=32'h80000000, b=4 then SLT a=-1, b=1 with req_valid held -> 32'h08000000 then 1. The second op is accepted only after the first handshake.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the 32-bit ALU: it drives the operands and the function
// code, holds them for the ALU or divider latency, and returns the result over valid/ready.
module alu_op_sequencer #(
    parameter int unsigned ALU_LAT    = 2,
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [5:0]  NOP_FUNCT  = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic [5:0]  alu_signal,
    output logic        alu_reset,
    input  logic [31:0] alu_dataOut,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned MAX_LAT = (ALU_LAT > DIV_CYCLES) ? ALU_LAT : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [FUNCT_W-1:0] F_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_DIV,
        CLS_ERR
    } op_class_e;

    state_e               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [DATA_W-1:0]    data_a_d, data_b_d, rsp_data_d;
    logic [FUNCT_W-1:0]   signal_d;
    logic                 rsp_valid_d, rsp_err_d;
    op_class_e            req_class;

    // MFHI/MFLO share the single-cycle path: the ALU returns HI/LO on dataOut.
    function automatic op_class_e classify(input logic [FUNCT_W-1:0] f);
        case (f)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h00, 6'h02, 6'h10, 6'h12: classify = CLS_ALU;
            F_DIVU:                             classify = CLS_DIV;
            default:                            classify = CLS_ERR;
        endcase
    endfunction

    assign req_class = classify(req_funct);
    assign alu_reset = reset;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        data_a_d    = alu_dataA;
        data_b_d    = alu_dataB;
        signal_d    = alu_signal;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    case (req_class)
                        CLS_ALU: begin
                            data_a_d = req_a;
                            data_b_d = req_b;
                            signal_d = req_funct;
                            cnt_d    = CNT_W'(ALU_LAT - 1);
                            state_d  = ST_EXEC;
                        end
                        CLS_DIV: begin
                            data_a_d = req_a;
                            data_b_d = req_b;
                            signal_d = req_funct;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            state_d  = ST_DIV_WAIT;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                            state_d     = ST_RESP;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_dataOut;
                    rsp_err_d   = 1'b0;
                    signal_d    = NOP_FUNCT;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_DIV_WAIT: begin
                // Acknowledge only; quotient and remainder are fetched with MFLO/MFHI.
                if (cnt == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    signal_d    = NOP_FUNCT;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            alu_signal <= NOP_FUNCT;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            alu_dataA  <= data_a_d;
            alu_dataB  <= data_b_d;
            alu_signal <= signal_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_err    <= rsp_err_d;
            req_ready  <= (state_d == ST_IDLE);
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule
